// File: rtl/sap1_controller_if.sv
// Opcode and control-word bundle between the SAP-1 instruction register/datapath and its sequencer.
// The controller is the slave (consumes opcode, drives controls); the datapath side is the master.
interface sap1_controller_if;
    logic [3:0] opcode;
    logic       Cp;
    logic       Ep;
    logic       Lm;
    logic       CE;
    logic       Li;
    logic       Ei;
    logic       La;
    logic       Ea;
    logic       Su;
    logic       Eu;
    logic       Lb;
    logic       Lo;
    logic [5:0] t_state;
    logic       halted;

    modport slave (
        input  opcode,
        output Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, t_state, halted
    );

    modport master (
        output opcode,
        input  Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, t_state, halted
    );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot ring (T1..T6) emitting the 12-bit control word.
// HLT freezes the ring at all-zero until reset.
module sap1_controller #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic             CLK,
    input  logic             RST,
    sap1_controller_if.slave bus
);

    // State encoding is the t_state output itself; all-zero is the halted freeze.
    typedef enum logic [5:0] {
        S_T1   = 6'b000001,
        S_T2   = 6'b000010,
        S_T3   = 6'b000100,
        S_T4   = 6'b001000,
        S_T5   = 6'b010000,
        S_T6   = 6'b100000,
        S_HALT = 6'b000000
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] opcode_reg;
    logic [3:0] op_dec;

    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= S_T1;
            opcode_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T4) begin
                opcode_reg <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = (bus.opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = S_T1;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_T1;
        endcase
    end

    // T4 decodes the live opcode because the latch only captures it at the end of T4.
    assign op_dec = (state_reg == S_T4) ? bus.opcode : opcode_reg;

    always_comb begin
        cp = 1'b0; ep = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0;
        lm = 1'b1; ce = 1'b1; li = 1'b1; ei = 1'b1; la = 1'b1; lb = 1'b1; lo = 1'b1;
        case (state_reg)
            S_T1: begin
                ep = 1'b1;
                lm = 1'b0;
            end
            S_T2: cp = 1'b1;
            S_T3: begin
                ce = 1'b0;
                li = 1'b0;
            end
            S_T4: begin
                case (op_dec)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        lm = 1'b0;
                        ei = 1'b0;
                    end
                    OP_OUT: begin
                        ea = 1'b1;
                        lo = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_dec)
                    OP_LDA: begin
                        ce = 1'b0;
                        la = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ce = 1'b0;
                        lb = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (op_dec == OP_ADD || op_dec == OP_SUB) begin
                    la = 1'b0;
                    eu = 1'b1;
                    su = (op_dec == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign bus.Cp      = cp;
    assign bus.Ep      = ep;
    assign bus.Lm      = lm;
    assign bus.CE      = ce;
    assign bus.Li      = li;
    assign bus.Ei      = ei;
    assign bus.La      = la;
    assign bus.Ea      = ea;
    assign bus.Su      = su;
    assign bus.Eu      = eu;
    assign bus.Lb      = lb;
    assign bus.Lo      = lo;
    assign bus.t_state = state_reg;
    assign bus.halted  = (state_reg == S_HALT);

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: directed scenarios with literal expectations, then random opcodes/resets
// checked every cycle against a step-counter model of the SAP-1 instruction cycle.
module tb_sap1_controller;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    sap1_controller_if bus_if ();

    sap1_controller dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.slave)
    );

    always #5 CLK = ~CLK;

    // Control word order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo (bit 11 down to 0).
    localparam logic [11:0] LOW_MASK = 12'h3E3;
    localparam logic [11:0] NOP      = 12'h3E3;

    logic [11:0] word;
    assign word = {bus_if.Cp, bus_if.Ep, bus_if.Lm, bus_if.CE, bus_if.Li, bus_if.Ei,
                   bus_if.La, bus_if.Ea, bus_if.Su, bus_if.Eu, bus_if.Lb, bus_if.Lo};

    int n_vec  = 0;
    int n_fail = 0;

    // Model: step 0..5 within the instruction, halt flag, instruction opcode taken at step 3.
    int       m_step  = 0;
    bit       m_halt  = 1'b0;
    bit       m_valid = 1'b0;
    bit [3:0] m_op    = 4'd0;

    // Asserted controls for a step, as an active-high mask, converted to pin levels by XOR.
    function automatic logic [11:0] expect_word(int step, logic [3:0] op);
        logic [11:0] a;
        a = 12'h000;
        case (step)
            0: a = 12'h600;                                   // Ep, Lm
            1: a = 12'h800;                                   // Cp
            2: a = 12'h180;                                   // CE, Li
            3: if (op <= 4'd2) a = 12'h240;                   // Lm, Ei
               else if (op == 4'he) a = 12'h011;              // Ea, Lo
            4: if (op == 4'd0) a = 12'h120;                   // CE, La
               else if (op == 4'd1 || op == 4'd2) a = 12'h102; // CE, Lb
            5: if (op == 4'd1) a = 12'h024;                   // La, Eu
               else if (op == 4'd2) a = 12'h02C;              // La, Eu, Su
            default: a = 12'h000;
        endcase
        return a ^ LOW_MASK;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_step  <= 0;
            m_halt  <= 1'b0;
            m_op    <= 4'd0;
            m_valid <= 1'b1;
        end else if (m_valid && !m_halt) begin
            if (m_step == 3) begin
                m_op <= bus_if.opcode;
                if (bus_if.opcode == 4'hf) m_halt <= 1'b1;
                else m_step <= 4;
            end else begin
                m_step <= (m_step + 1) % 6;
            end
        end
    end

    task automatic check(string name, logic [11:0] actual, logic [11:0] required);
        n_vec++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge CLK) begin
        if (m_valid) begin
            logic [11:0] exp_w;
            logic [5:0]  exp_t;
            exp_t = m_halt ? 6'b000000 : 6'(1 << m_step);
            if (m_halt) exp_w = NOP;
            else if (m_step == 3) exp_w = expect_word(3, bus_if.opcode);
            else exp_w = expect_word(m_step, m_op);
            check("t_state", {6'b0, bus_if.t_state}, {6'b0, exp_t});
            check("halted", {11'b0, bus_if.halted}, {11'b0, m_halt});
            check("ctrl_word", word, exp_w);
            check("bus_excl",
                  {10'b0, ($countones({bus_if.Ep, bus_if.Ea, bus_if.Eu}) <= 1),
                          ($countones({~bus_if.CE, ~bus_if.Ei}) <= 1)},
                  12'h003);
        end
    end

    task automatic step(bit rst, logic [3:0] op);
        RST           = rst;
        bus_if.opcode = op;
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(int n, logic [3:0] op);
        for (int i = 0; i < n; i++) step(1'b0, op);
    endtask

    initial begin
        bus_if.opcode = 4'd0;

        // Reset -> T1 fetch word
        step(1'b1, 4'd0);
        check("reset_tstate", {6'b0, bus_if.t_state}, 12'h001);
        check("reset_halted", {11'b0, bus_if.halted}, 12'h000);
        check("reset_word", word, 12'h5E3);

        // LDA full instruction
        steps(3, 4'd0);
        check("lda_t4", word, 12'h1A3);
        steps(2, 4'd0);
        check("lda_t6_nop", word, NOP);
        steps(1, 4'd0);
        check("lda_back_t1", {6'b0, bus_if.t_state}, 12'h001);

        // SUB with opcode changed to HLT during T5
        steps(4, 4'd2);
        steps(1, 4'hf);
        check("sub_t6", word, 12'h3CF);
        check("sub_no_halt", {11'b0, bus_if.halted}, 12'h000);
        steps(1, 4'hf);

        // OUT then HLT
        steps(3, 4'he);
        check("out_t4", word, 12'h3F2);
        steps(3, 4'he);
        steps(4, 4'hf);
        check("hlt_halted", {11'b0, bus_if.halted}, 12'h001);
        check("hlt_tstate", {6'b0, bus_if.t_state}, 12'h000);
        for (int i = 0; i < 20; i++) step(1'b0, 4'($urandom_range(0, 15)));
        check("hlt_hold_word", word, NOP);
        step(1'b1, 4'd1);
        check("hlt_exit_t1", {6'b0, bus_if.t_state}, 12'h001);

        // Reset during T5 of ADD
        steps(4, 4'd1);
        step(1'b1, 4'd1);
        check("midrst_word", word, 12'h5E3);

        // Every non-halting opcode for one full instruction, then undefined 0111 pinned
        for (int op = 0; op < 15; op++) steps(6, 4'(op));
        steps(3, 4'd7);
        check("undef_t4", word, NOP);
        steps(3, 4'd7);
        check("undef_t1", {6'b0, bus_if.t_state}, 12'h001);

        // Random opcodes with occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)));

        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
